// File: rtl/axi_to_mem_pkg.sv
// +----------------------------------------------------------------------------+
// | axi_to_mem_pkg : FSM state encoding for the AXI-to-SRAM bridge               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package axi_to_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/soc_pkg.sv
// +----------------------------------------------------------------------------+
// | soc_pkg : SoC AXI4 slave-port types, burst encodings and response codes      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package soc_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    ax_chan_t ar;
    logic     ar_valid;
    logic     b_ready;
    logic     r_ready;
  } s_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    logic    ar_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } s_resp_t;

endpackage

`default_nettype wire

// File: rtl/axi_to_mem_if.sv
// +----------------------------------------------------------------------------+
// | axi_to_mem_if : AXI request/response bundle between SoC RAM port and bridge  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface axi_to_mem_if;
  import soc_pkg::*;

  s_req_t  req;
  s_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

`default_nettype wire

// File: rtl/axi_burst_addr.sv
// +----------------------------------------------------------------------------+
// | axi_burst_addr : combinational AXI4 next-beat address (FIXED/INCR/WRAP)      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_burst_addr
  import soc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_len_ok;

  always_comb begin
    step        = ADDR_WIDTH'(1) << size_i;
    aligned     = addr_i & ~(step - ADDR_WIDTH'(1));
    incr        = aligned + step;
    wrap_mask   = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    next_addr_o = incr;
    if (burst_i == BURST_FIXED) begin
      next_addr_o = addr_i;
    end else if ((burst_i == BURST_WRAP) && wrap_len_ok) begin
      // Non power-of-two WRAP lengths fall through to INCR.
      next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_to_mem.sv
// +----------------------------------------------------------------------------+
// | axi_to_mem : AXI4 slave to 1-cycle-latency single-port SRAM bridge           |
// | Optional macro AXI_TO_MEM_RANGE_CHECK_EN enables window range SLVERR.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_to_mem
  import soc_pkg::*;
  import axi_to_mem_pkg::*;
#(
  parameter logic [63:0]  MEM_BASE   = 64'h0,
  parameter int unsigned  MEM_SIZE   = 29,
  parameter int unsigned  DATA_WIDTH = 64,
  parameter type          req_t      = soc_pkg::s_req_t,
  parameter type          resp_t     = soc_pkg::s_resp_t,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned OFF_W      = $clog2(NB)
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  req_t                      req_i,
  output resp_t                     resp_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [MEM_SIZE-OFF_W-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [NB-1:0]             mem_strb_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

`ifdef AXI_TO_MEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

  function automatic logic oob(input logic [63:0] a);
    logic [64:0] diff;
    diff = {1'b0, a} - {1'b0, MEM_BASE};
    return RANGE_CHECK && (diff[64] || ((diff[63:0] >> MEM_SIZE) != 64'd0));
  endfunction

  state_e          state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [63:0]     addr_q, addr_d;
  logic [7:0]      len_q, len_d, beat_q, beat_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic            err_q, err_d;
  logic            last_write_q, last_write_d;
  logic [63:0]     next_addr;
  logic [63:0]     offset;
  logic            grant_write;
  ax_chan_t        ax;
  logic            unused_bits;

  axi_burst_addr #(.ADDR_WIDTH(64)) u_burst_addr (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // Out-of-window bits are discarded, which gives modulo addressing without the range check.
  assign offset      = addr_q - MEM_BASE;
  assign unused_bits = ^{offset[63:MEM_SIZE], offset[OFF_W-1:0], req_i.w.last};

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    err_d        = err_q;
    last_write_d = last_write_q;
    resp_o       = '0;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_strb_o   = '0;
    grant_write  = req_i.aw_valid && (!req_i.ar_valid || !last_write_q);
    ax           = grant_write ? req_i.aw : req_i.ar;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_write || req_i.ar_valid) begin
          resp_o.aw_ready = grant_write;
          resp_o.ar_ready = !grant_write;
          id_d            = ax.id;
          addr_d          = ax.addr;
          len_d           = ax.len;
          size_d          = ax.size;
          burst_d         = ax.burst;
          beat_d          = '0;
          err_d           = oob(ax.addr) || (ax.size > MAX_SIZE);
          last_write_d    = grant_write;
          state_d         = grant_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        resp_o.w_ready = 1'b1;
        if (req_i.w_valid) begin
          if (!err_q) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = offset[MEM_SIZE-1:OFF_W];
            mem_wdata_o = req_i.w.data;
            mem_strb_o  = req_i.w.strb;
          end
          if (beat_q == len_q) begin
            state_d = ST_WRESP;
          end else begin
            addr_d = next_addr;
            beat_d = beat_q + 8'd1;
            err_d  = err_q || oob(next_addr);
          end
        end
      end
      ST_WRESP: begin
        resp_o.b_valid = 1'b1;
        resp_o.b.id    = id_q;
        resp_o.b.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (req_i.b_ready) state_d = ST_IDLE;
      end
      ST_READ: begin
        if (!err_q) begin
          mem_en_o   = 1'b1;
          mem_addr_o = offset[MEM_SIZE-1:OFF_W];
        end
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        resp_o.r_valid = 1'b1;
        resp_o.r.id    = id_q;
        resp_o.r.last  = (beat_q == len_q);
        resp_o.r.data  = err_q ? '0 : mem_rdata_i;
        resp_o.r.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (req_i.r_ready) begin
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 8'd1;
            err_d   = err_q || oob(next_addr);
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_write resets high so that the very first aw/ar tie goes to the read.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      last_write_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      last_write_q <= last_write_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_to_mem.sv
// +----------------------------------------------------------------------------+
// | tb_axi_to_mem : directed + randomized bench for axi_to_mem                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_axi_to_mem;
  import soc_pkg::*;

  localparam logic [63:0] BASE = 64'h0;
  localparam int          MSZ  = 29;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        mem_en, mem_we;
  logic [25:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = 64'h0;
  logic [7:0]  mem_strb;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int n_mem_acc = 0;
  int lens[6] = '{0, 1, 2, 3, 7, 15};

  bit [63:0] env_mem [bit [63:0]];
  bit [63:0] ref_mem [bit [63:0]];

  always #5 clk = ~clk;

  axi_to_mem_if bus ();

  axi_to_mem #(
    .MEM_BASE(BASE), .MEM_SIZE(MSZ), .DATA_WIDTH(64), .req_t(s_req_t), .resp_t(s_resp_t)
  ) dut (
    .clk_i(clk), .arst_ni(arst_n), .req_i(bus.req), .resp_o(bus.resp),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_rdata_i(mem_rdata)
  );

  // SRAM behaviour: byte-enabled write, read data registered and held until the next read.
  always @(posedge clk) begin
    bit [63:0] w;
    if (mem_en === 1'b1) begin
      n_mem_acc++;
      if (mem_we) begin
        w = env_mem.exists(64'(mem_addr)) ? env_mem[64'(mem_addr)] : 64'h0;
        for (int b = 0; b < 8; b++) if (mem_strb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        env_mem[64'(mem_addr)] = w;
      end else begin
        mem_rdata <= env_mem.exists(64'(mem_addr)) ? env_mem[64'(mem_addr)] : 64'h0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference address of beat i, straight from the AXI burst definitions.
  function automatic logic [63:0] beat_addr(logic [63:0] start, int len, int size, int burst, int i);
    logic [63:0] step, aligned, span, lower;
    step    = 64'd1 << size;
    aligned = start - (start % step);
    if (i == 0 || burst == 0) return start;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      span  = step * 64'(len + 1);
      lower = start - (start % span);
      return lower + ((aligned - lower + step * 64'(i)) % span);
    end
    return aligned + step * 64'(i);
  endfunction

  function automatic bit out_of_window(logic [63:0] a);
`ifdef AXI_TO_MEM_RANGE_CHECK_EN
    logic [64:0] d;
    d = {1'b0, a} - {1'b0, BASE};
    return d[64] || (d[63:0] >= (64'd1 << MSZ));
`else
    return (a === 64'hx);
`endif
  endfunction

  function automatic logic [63:0] word_of(logic [63:0] a);
    return ((a - BASE) >> 3) & ((64'd1 << (MSZ - 3)) - 64'd1);
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input int len,
                          input int size, input int burst, input bit rnd, output int waited);
    int cnt;
    bit err;
    logic [63:0] a, d, w0;
    logic [7:0] s;
    bus.req.aw = '{id: id, addr: addr, len: 8'(len), size: 3'(size), burst: 2'(burst)};
    bus.req.aw_valid = 1'b1;
    #1;
    cnt = 0;
    while (bus.resp.aw_ready !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    waited = cnt;
    check("aw_ready timeout", 64'(cnt < 50), 1);
    @(posedge clk); #1;
    bus.req.aw_valid = 1'b0;
    err = (size > 3);
    for (int i = 0; i <= len; i++) begin
      a   = beat_addr(addr, len, size, burst, i);
      err = err || out_of_window(a);
      d   = rnd ? {$urandom, $urandom} : 64'h1234567890ABCDEF + 64'(i);
      s   = rnd ? 8'($urandom) : 8'hFF;
      bus.req.w = '{data: d, strb: s, last: (i == len)};
      bus.req.w_valid = 1'b1;
      #1;
      check("w_ready", 64'(bus.resp.w_ready), 1);
      check("wr mem_en", 64'(mem_en), 64'(!err));
      if (!err) begin
        check("wr mem_we", 64'(mem_we), 1);
        check("wr mem_addr", 64'(mem_addr), word_of(a));
        check("wr mem_wdata", mem_wdata, d);
        check("wr mem_strb", 64'(mem_strb), 64'(s));
        w0 = ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 64'h0;
        for (int b = 0; b < 8; b++) if (s[b]) w0[8*b +: 8] = d[8*b +: 8];
        ref_mem[word_of(a)] = w0;
      end
      @(posedge clk); #1;
    end
    bus.req.w_valid = 1'b0;
    check("b_valid", 64'(bus.resp.b_valid), 1);
    check("b_id", 64'(bus.resp.b.id), 64'(id));
    check("b_resp", 64'(bus.resp.b.resp), err ? 64'd2 : 64'd0);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      check("b_valid hold", 64'(bus.resp.b_valid), 1);
    end
    bus.req.b_ready = 1'b1;
    @(posedge clk); #1;
    bus.req.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input int len,
                         input int size, input int burst, output int waited);
    int cnt;
    bit err;
    logic [63:0] a, e;
    bus.req.ar = '{id: id, addr: addr, len: 8'(len), size: 3'(size), burst: 2'(burst)};
    bus.req.ar_valid = 1'b1;
    #1;
    cnt = 0;
    while (bus.resp.ar_ready !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    waited = cnt;
    check("ar_ready timeout", 64'(cnt < 50), 1);
    @(posedge clk); #1;
    bus.req.ar_valid = 1'b0;
    err = (size > 3);
    for (int i = 0; i <= len; i++) begin
      a   = beat_addr(addr, len, size, burst, i);
      err = err || out_of_window(a);
      check("rd mem_en", 64'(mem_en), 64'(!err));
      check("rd aw_ready busy", 64'(bus.resp.aw_ready), 0);
      if (!err) begin
        check("rd mem_we", 64'(mem_we), 0);
        check("rd mem_addr", 64'(mem_addr), word_of(a));
      end
      @(posedge clk); #1;
      e = err ? 64'h0 : (ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 64'h0);
      check("r_valid", 64'(bus.resp.r_valid), 1);
      check("r_data", bus.resp.r.data, e);
      check("r_resp", 64'(bus.resp.r.resp), err ? 64'd2 : 64'd0);
      check("r_last", 64'(bus.resp.r.last), 64'(i == len));
      check("r_id", 64'(bus.resp.r.id), 64'(id));
      check("rdata mem_en", 64'(mem_en), 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("r_data hold", bus.resp.r.data, e);
      end
      bus.req.r_ready = 1'b1;
      @(posedge clk); #1;
      bus.req.r_ready = 1'b0;
    end
  endtask

  initial begin
    int wt, acc;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset resp", 64'(bus.resp === '0), 1);
    check("reset mem_en", 64'(mem_en), 0);
    check("reset mem_we", 64'(mem_we), 0);
    check("reset mem_addr", 64'(mem_addr), 0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // First-ever aw/ar tie goes to the read.
    bus.req.aw = '{id: 4'h1, addr: BASE, len: 8'd0, size: 3'd3, burst: 2'd1};
    bus.req.ar = '{id: 4'h2, addr: BASE + 64'h40, len: 8'd0, size: 3'd3, burst: 2'd1};
    bus.req.aw_valid = 1'b1;
    bus.req.ar_valid = 1'b1;
    #1;
    check("tie0 ar_ready", 64'(bus.resp.ar_ready), 1);
    check("tie0 aw_ready", 64'(bus.resp.aw_ready), 0);
    do_read(4'h2, BASE + 64'h40, 0, 3, 1, wt);
    // Single full-width write then read-back of the fixed pattern.
    do_write(4'h1, BASE, 0, 3, 1, 1'b0, wt);
    check("write after read waited", 64'(wt), 0);
    do_read(4'h3, BASE, 0, 3, 1, wt);
    // INCR len=3 at +0x20 and a fill of words 1..3 for the WRAP read.
    do_write(4'h4, BASE + 64'h20, 3, 3, 1, 1'b0, wt);
    do_write(4'h5, BASE + 64'h8, 2, 3, 1, 1'b1, wt);
    do_read(4'h6, BASE + 64'h18, 3, 3, 2, wt);

    // Read served last, so a tie now goes to the write; the read follows right after B.
    bus.req.aw = '{id: 4'h7, addr: BASE + 64'h30, len: 8'd1, size: 3'd3, burst: 2'd1};
    bus.req.ar = '{id: 4'h8, addr: BASE + 64'h30, len: 8'd1, size: 3'd3, burst: 2'd1};
    bus.req.aw_valid = 1'b1;
    bus.req.ar_valid = 1'b1;
    #1;
    check("tie1 aw_ready", 64'(bus.resp.aw_ready), 1);
    check("tie1 ar_ready", 64'(bus.resp.ar_ready), 0);
    do_write(4'h7, BASE + 64'h30, 1, 3, 1, 1'b1, wt);
    do_read(4'h8, BASE + 64'h30, 1, 3, 1, wt);
    check("read after B waited", 64'(wt), 0);

    // Access just past the window end.
    do_read(4'h9, BASE + (64'd1 << MSZ), 0, 3, 1, wt);
    // Oversized beat.
    do_write(4'hA, BASE + 64'h80, 1, 4, 1, 1'b1, wt);

    // Reset pulsed during beat 2 of a len=7 write.
    do_write(4'hB, BASE + 64'h110, 1, 3, 1, 1'b1, wt);
    bus.req.aw = '{id: 4'hC, addr: BASE + 64'h100, len: 8'd7, size: 3'd3, burst: 2'd1};
    bus.req.aw_valid = 1'b1;
    @(posedge clk); #1;
    bus.req.aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req.w = '{data: 64'hA5A5_0000_0000_0000 + 64'(i), strb: 8'hFF, last: 1'b0};
      bus.req.w_valid = 1'b1;
      ref_mem[word_of(BASE + 64'h100 + 64'(8 * i))] = 64'hA5A5_0000_0000_0000 + 64'(i);
      @(posedge clk); #1;
    end
    bus.req.w = '{data: 64'hDEAD_BEEF_0000_0002, strb: 8'hFF, last: 1'b0};
    arst_n = 1'b0;
    #1;
    check("rst resp", 64'(bus.resp === '0), 1);
    check("rst mem_en", 64'(mem_en), 0);
    check("rst mem_we", 64'(mem_we), 0);
    check("rst mem_wdata", mem_wdata, 0);
    acc = n_mem_acc;
    bus.req.w_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no beats after reset", 64'(n_mem_acc), 64'(acc));
    check("idle aw_ready", 64'(bus.resp.aw_ready), 0);
    do_write(4'hD, BASE + 64'h200, 0, 3, 1, 1'b1, wt);
    check("aw_ready after reset", 64'(wt), 0);
    do_read(4'hE, BASE + 64'h100, 3, 3, 1, wt);

    // Randomized traffic against the reference memory.
    for (int t = 0; t < 40; t++) begin
      int sz, bu, ln;
      logic [63:0] ad;
      logic [3:0] idr;
      sz  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      bu  = int'($urandom_range(0, 2));
      ln  = lens[$urandom_range(0, 5)];
      idr = 4'($urandom);
      if ($urandom_range(0, 3) == 0) ad = BASE + (64'd1 << MSZ) - 64'(8 * $urandom_range(1, 4));
      else ad = BASE + 64'($urandom_range(0, 63) * 8 + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_write(idr, ad, ln, sz, bu, 1'b1, wt);
      else do_read(idr, ad, ln, sz, bu, wt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
